// File: rtl/multiplier_unsigned_if.sv
// Limb bus for the wide multiplier. The master drives operands A and B and
// receives the product M; the slave is the multiplier.
interface multiplier_unsigned_if #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17
);
  logic [BIT_LEN-1:0] A [NUM_ELEMENTS];
  logic [BIT_LEN-1:0] B [NUM_ELEMENTS];
  logic [BIT_LEN-1:0] M [2*NUM_ELEMENTS];

  modport master (output A, output B, input M);
  modport slave  (input A, input B, output M);
endinterface

// File: rtl/multiplier_unsigned.sv
// Wide unsigned multiplier giving a redundant-limb product through per-column CSA trees.
// Latency 1 cycle, one product per cycle, no backpressure (a new operand pair is taken every edge).
module multiplier_unsigned #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplier_unsigned_if.slave bus
);

  localparam int NC   = 2 * NUM_ELEMENTS;
  // Rows per column: N low halves, N high halves, two carry rows from below,
  // rounded up to a multiple of three so every compressor group is in range.
  localparam int MAXR = 3 * ((2 * NUM_ELEMENTS + 4) / 3);
  // Wide enough to hold the full sum of every row in a column without wrap.
  localparam int CW   = WORD_LEN + $clog2(2 * NUM_ELEMENTS + 2) + 1;

  typedef logic [CW-1:0] row_t;

  function automatic logic [2*CW-1:0] csa_tree(input row_t in_rows [MAXR]);
    row_t cur [MAXR];
    row_t nxt [MAXR];
    int   n;
    int   m;
    cur = in_rows;
    n   = MAXR;
    for (int p = 0; p < MAXR; p++) begin
      if (n > 2) begin
        m = 0;
        for (int r = 0; r < MAXR; r++) nxt[r] = '0;
        for (int g = 0; g < MAXR; g += 3) begin
          if (g + 2 < n) begin
            nxt[m]     = cur[g] ^ cur[g+1] ^ cur[g+2];
            nxt[m + 1] = ((cur[g] & cur[g+1]) | (cur[g] & cur[g+2]) |
                          (cur[g+1] & cur[g+2])) << 1;
            m += 2;
          end else begin
            if (g < n) begin
              nxt[m] = cur[g];
              m++;
            end
            if (g + 1 < n) begin
              nxt[m] = cur[g+1];
              m++;
            end
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    return {cur[1], cur[0]};
  endfunction

  logic [2*WORD_LEN-1:0] pp  [NUM_ELEMENTS][NUM_ELEMENTS];
  logic [BIT_LEN-1:0]    m_d [NC];
  logic [BIT_LEN-1:0]    m_q [NC];

  // Bit WORD_LEN of each input limb is dropped here so it never reaches the datapath.
  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_pp_i
    for (genvar k = 0; k < NUM_ELEMENTS; k++) begin : g_pp_k
      assign pp[i][k] = {{WORD_LEN{1'b0}}, bus.A[i][WORD_LEN-1:0]} *
                        {{WORD_LEN{1'b0}}, bus.B[k][WORD_LEN-1:0]};
    end
  end

  for (genvar j = 0; j < NC; j++) begin : col
    row_t              rows [MAXR];
    row_t              cin_s;
    row_t              cin_c;
    row_t              hi_s;
    row_t              hi_c;
    logic [2*CW-1:0]   red;
    row_t              sum_row;
    row_t              car_row;

    if (j > 0) begin : g_cin
      assign cin_s = col[j-1].hi_s;
      assign cin_c = col[j-1].hi_c;
    end else begin : g_no_cin
      assign cin_s = '0;
      assign cin_c = '0;
    end

    always_comb begin
      for (int r = 0; r < MAXR; r++) rows[r] = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if ((j - i >= 0) && (j - i < NUM_ELEMENTS))
          rows[i] = row_t'(pp[i][j-i][WORD_LEN-1:0]);
        if ((j - 1 - i >= 0) && (j - 1 - i < NUM_ELEMENTS))
          rows[NUM_ELEMENTS+i] = row_t'(pp[i][j-1-i][2*WORD_LEN-1:WORD_LEN]);
      end
      rows[2*NUM_ELEMENTS]   = cin_s;
      rows[2*NUM_ELEMENTS+1] = cin_c;
    end

    assign red     = csa_tree(rows);
    assign sum_row = red[CW-1:0];
    assign car_row = red[2*CW-1:CW];

    // Overflow above the limb radix moves up a column; the top column's is always zero.
    assign hi_s = row_t'(sum_row[CW-1:WORD_LEN]);
    assign hi_c = row_t'(car_row[CW-1:WORD_LEN]);

    assign m_d[j] = {1'b0, sum_row[WORD_LEN-1:0]} + {1'b0, car_row[WORD_LEN-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NC; j++) m_q[j] <= '0;
    end else begin
      for (int j = 0; j < NC; j++) m_q[j] <= m_d[j];
    end
  end

  assign bus.M = m_q;

endmodule

// File: tb/tb_multiplier_unsigned.sv
// Bench for multiplier_unsigned: compares recomposed products against plain wide arithmetic.
module tb_multiplier_unsigned;

  localparam int N  = 17;
  localparam int BL = 17;
  localparam int W  = 16;

  typedef logic [575:0] big_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multiplier_unsigned_if #(.NUM_ELEMENTS(N), .BIT_LEN(BL)) bus ();

  multiplier_unsigned #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic big_t op_mask();
    big_t one;
    one = 1;
    return (one << (N * W)) - 1;
  endfunction

  function automatic big_t rand_op();
    big_t v;
    v = '0;
    for (int i = 0; i < 18; i++) v[32*i +: 32] = $urandom;
    return v & op_mask();
  endfunction

  function automatic big_t mval();
    big_t v;
    big_t t;
    v = '0;
    for (int j = 0; j < 2 * N; j++) begin
      t = '0;
      t[W-1:0] = bus.M[j][W-1:0];
      v = v + (t << (W * j));
      t = '0;
      t[0] = bus.M[j][W];
      v = v + (t << (W * (j + 1)));
    end
    return v;
  endfunction

  // mode16: 0 = bit16 clear, 1 = bit16 set, 2 = bit16 random
  task automatic drive(input big_t a, input big_t b, input int mode16);
    for (int i = 0; i < N; i++) begin
      bus.A[i] = {(mode16 == 1) ? 1'b1 : (mode16 == 2) ? 1'($urandom) : 1'b0, a[W*i +: W]};
      bus.B[i] = {(mode16 == 1) ? 1'b1 : (mode16 == 2) ? 1'($urandom) : 1'b0, b[W*i +: W]};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    big_t a, b, got;
    logic any_set;
    rst = 1'b1;
    a = rand_op() | 1;
    b = rand_op() | 1;
    drive(a, b, 2);
    step();
    step();
    got = mval();
    any_set = 1'b0;
    for (int j = 0; j < 2 * N; j++) any_set = any_set | (|bus.M[j]);
    checks++;
    if (got !== '0 || any_set !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %h limbs_nonzero %b, expected 0", got, any_set);
    end
    rst = 1'b0;
    step();
    got = mval();
    checks++;
    if (got !== a * b) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", got, a * b);
    end
    a = rand_op() | 1;
    b = rand_op() | 1;
    drive(a, b, 0);
    step();
    got = mval();
    checks++;
    if (got !== a * b) begin
      errors++;
      $display("FAIL pre_async_reset: got %h expected %h", got, a * b);
    end
    #2 rst = 1'b1;
    #1;
    got = mval();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", got);
    end
    step();
    rst = 1'b0;
    a = rand_op();
    b = rand_op();
    drive(a, b, 2);
    step();
    got = mval();
    checks++;
    if (got !== a * b) begin
      errors++;
      $display("FAIL after_async_reset: got %h expected %h", got, a * b);
    end
  endtask

  task automatic test_zero_identity();
    big_t a, b, got;
    b = rand_op();
    drive('0, b, 2);
    step();
    got = mval();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL zero_a: got %h expected 0", got);
    end
    a = rand_op();
    drive(a, '0, 2);
    step();
    got = mval();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL zero_b: got %h expected 0", got);
    end
    b = rand_op();
    drive(big_t'(1), b, 0);
    step();
    got = mval();
    checks++;
    if (got !== b) begin
      errors++;
      $display("FAIL identity: got %h expected %h", got, b);
    end
  endtask

  task automatic test_max();
    big_t mx, exp_v, got;
    mx = op_mask();
    exp_v = mx * mx;
    for (int mode = 0; mode < 3; mode++) begin
      drive(mx, mx, mode);
      step();
      got = mval();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL max_mode%0d: got %h expected %h", mode, got, exp_v);
      end
    end
  endtask

  task automatic test_single_limb();
    big_t a, exp_v, got;
    a = big_t'(16'hFFFF) << 256;
    exp_v = big_t'(32'hFFFE0001) << 512;
    drive(a, a, 0);
    step();
    got = mval();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL single_limb: got %h expected %h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    big_t a, b, exp_q[$], got, e;
    for (int c = 0; c <= 300; c++) begin
      if (c < 300) begin
        a = rand_op();
        b = rand_op();
        if (c % 7 == 3) a = a >> ($urandom_range(0, 271));
        drive(a, b, 2);
        exp_q.push_back(a * b);
      end
      step();
      if (exp_q.size() > 0 && (c > 0 || c == 0)) begin
        e = exp_q.pop_front();
        got = mval();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL random_cycle%0d: got %h expected %h", c, got, e);
          break;
        end
      end
    end
  endtask

  task automatic test_pipeline();
    big_t mx, sq, got, e;
    mx = op_mask();
    sq = mx * mx;
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) drive(mx, mx, 2);
      else            drive('0, mx, 2);
      e = (c % 2 == 0) ? sq : '0;
      step();
      got = mval();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pipeline_cycle%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_zero_identity();
    test_max();
    test_single_limb();
    test_back_to_back();
    test_pipeline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
